// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync_gen to the pixel-draw stage.
// master drives, slave (draw stage) consumes.
interface vga_sync_if;
    logic       Pix_Tick_Out;
    logic [9:0] Val_Row_Out;
    logic [9:0] Val_Col_Out;
    logic       Disp_Ena_Out;
    logic       HSync_Out;
    logic       VSync_Out;
    logic       Frame_Start_Out;

    modport master (
        output Pix_Tick_Out,
        output Val_Row_Out,
        output Val_Col_Out,
        output Disp_Ena_Out,
        output HSync_Out,
        output VSync_Out,
        output Frame_Start_Out
    );

    modport slave (
        input Pix_Tick_Out,
        input Val_Row_Out,
        input Val_Col_Out,
        input Disp_Ena_Out,
        input HSync_Out,
        input VSync_Out,
        input Frame_Start_Out
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-tick divider, row/col counters, syncs and enable.
// Define VGA_SYNC_DELAY_EN to delay HSync/VSync by one clock.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_In,
    vga_sync_if.master vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       row_q, row_d;
    logic [9:0]       col_q, col_d;
    logic             tick_q, tick_d;
    logic             fs_q, fs_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    // Every output is decoded from the next-state counters so that,
    // once registered, it lines up with Row/Col in the same cycle.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_d == DIV_LAST);
        row_d  = row_q;
        col_d  = col_q;
        fs_d   = 1'b0;
        if (tick_d) begin
            if (row_q == H_LAST) begin
                row_d = '0;
                if (col_q == V_LAST) begin
                    col_d = '0;
                    fs_d  = 1'b1;
                end else begin
                    col_d = col_q + 10'd1;
                end
            end else begin
                row_d = row_q + 10'd1;
            end
        end
        de_d = (row_d < H_VIS) && (col_d < V_VIS);
        hs_d = !((row_d >= HS_BEG) && (row_d < HS_END));
        vs_d = !((col_d >= VS_BEG) && (col_d < VS_END));
    end

    always_ff @(posedge Master_Clock_In) begin
        if (Reset_In) begin
            div_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            row_q  <= row_d;
            col_q  <= col_d;
            tick_q <= tick_d;
            fs_q   <= fs_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign vga.Pix_Tick_Out    = tick_q;
    assign vga.Val_Row_Out     = row_q;
    assign vga.Val_Col_Out     = col_q;
    assign vga.Disp_Ena_Out    = de_q;
    assign vga.Frame_Start_Out = fs_q;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stage matches the draw stage's registered colour output.
    logic hs_dly_q, hs_dly_d;
    logic vs_dly_q, vs_dly_d;

    always_comb begin
        hs_dly_d = hs_q;
        vs_dly_d = vs_q;
    end

    always_ff @(posedge Master_Clock_In) begin
        if (Reset_In) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign vga.HSync_Out = hs_dly_q;
    assign vga.VSync_Out = vs_dly_q;
`else
    assign vga.HSync_Out = hs_q;
    assign vga.VSync_Out = vs_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance and a default 640x480 one,
// both compared every cycle against an arithmetic model under random resets.
module tb_vga_sync_gen;

    localparam int S_CD = 3;
    localparam int S_HV = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VV = 6;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 2;
    localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB)
                           * (S_VV + S_VF + S_VS + S_VB) * S_CD;

    typedef struct {
        int row;
        int col;
        bit tick;
        bit fs;
        bit de;
        bit hs;
        bit vs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_if s_if ();
    vga_sync_if d_if ();

    vga_sync_gen #(
        .CLK_DIV  (S_CD),
        .H_VISIBLE(S_HV),
        .H_FRONT  (S_HF),
        .H_SYNC   (S_HS),
        .H_BACK   (S_HB),
        .V_VISIBLE(S_VV),
        .V_FRONT  (S_VF),
        .V_SYNC   (S_VS),
        .V_BACK   (S_VB)
    ) u_small (
        .Master_Clock_In(clk),
        .Reset_In       (rst),
        .vga            (s_if.master)
    );

    vga_sync_gen u_dflt (
        .Master_Clock_In(clk),
        .Reset_In       (rst),
        .vga            (d_if.master)
    );

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n       = 0;
    int   cyc_cnt = 0;
    int   last_fs = -1;
    int   de_cnt  = 0;
    exp_t es;
    exp_t ed;
    bit   s_hs_e, s_vs_e, d_hs_e, d_vs_e;
    bit   s_hs_prev = 1'b1;
    bit   s_vs_prev = 1'b1;
    bit   d_hs_prev = 1'b1;
    bit   d_vs_prev = 1'b1;

    // n = clock edges since the last reset edge; n==0 is the reset state.
    function automatic exp_t ref_model(int nn, int cd,
                                       int hv, int hf, int hsw, int hb,
                                       int vv, int vf, int vsw, int vb);
        exp_t e;
        int   ht;
        int   vt;
        int   p;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (nn == 0) begin
            e.row = 0; e.col = 0; e.tick = 0; e.fs = 0;
            e.de = 0; e.hs = 1; e.vs = 1;
            return e;
        end
        p      = (nn + 1) / cd - ((cd == 1) ? 1 : 0);
        e.row  = p % ht;
        e.col  = (p / ht) % vt;
        e.tick = ((nn % cd) == cd - 1);
        e.fs   = e.tick && ((p % (ht * vt)) == 0);
        e.de   = (e.row < hv) && (e.col < vv);
        e.hs   = !((e.row >= hv + hf) && (e.row < hv + hf + hsw));
        e.vs   = !((e.col >= vv + vf) && (e.col < vv + vf + vsw));
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      tag, got, exp, cyc_cnt);
    endtask

    task automatic check_dut(string nm, exp_t e, bit hs_e, bit vs_e,
                             logic [9:0] row, logic [9:0] col,
                             logic tick, logic fs, logic de,
                             logic hs, logic vs);
        chk({nm, ".row"},  32'(row),  32'(e.row));
        chk({nm, ".col"},  32'(col),  32'(e.col));
        chk({nm, ".tick"}, 32'(tick), 32'(e.tick));
        chk({nm, ".fs"},   32'(fs),   32'(e.fs));
        chk({nm, ".de"},   32'(de),   32'(e.de));
        chk({nm, ".hs"},   32'(hs),   32'(hs_e));
        chk({nm, ".vs"},   32'(vs),   32'(vs_e));
    endtask

    task automatic cyc(input bit r);
        rst = r;
        @(posedge clk);
        n = r ? 0 : n + 1;
        cyc_cnt++;
        es = ref_model(n, S_CD, S_HV, S_HF, S_HS, S_HB,
                       S_VV, S_VF, S_VS, S_VB);
        ed = ref_model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
`ifdef VGA_SYNC_DELAY_EN
        s_hs_e = r ? 1'b1 : s_hs_prev;
        s_vs_e = r ? 1'b1 : s_vs_prev;
        d_hs_e = r ? 1'b1 : d_hs_prev;
        d_vs_e = r ? 1'b1 : d_vs_prev;
`else
        s_hs_e = es.hs;
        s_vs_e = es.vs;
        d_hs_e = ed.hs;
        d_vs_e = ed.vs;
`endif
        s_hs_prev = es.hs;
        s_vs_prev = es.vs;
        d_hs_prev = ed.hs;
        d_vs_prev = ed.vs;
        @(negedge clk);
        check_dut("small", es, s_hs_e, s_vs_e,
                  s_if.Val_Row_Out, s_if.Val_Col_Out, s_if.Pix_Tick_Out,
                  s_if.Frame_Start_Out, s_if.Disp_Ena_Out,
                  s_if.HSync_Out, s_if.VSync_Out);
        check_dut("dflt", ed, d_hs_e, d_vs_e,
                  d_if.Val_Row_Out, d_if.Val_Col_Out, d_if.Pix_Tick_Out,
                  d_if.Frame_Start_Out, d_if.Disp_Ena_Out,
                  d_if.HSync_Out, d_if.VSync_Out);
        // Frame-level properties seen purely from the small DUT's outputs.
        if (r) begin
            last_fs = -1;
            de_cnt  = 0;
        end else begin
            if (s_if.Frame_Start_Out === 1'b1) begin
                if (last_fs >= 0) begin
                    chk("fs_period", 32'(cyc_cnt - last_fs), 32'(S_FRAME));
                    chk("de_pixels", 32'(de_cnt), 32'(S_HV * S_VV));
                end
                last_fs = cyc_cnt;
                de_cnt  = 0;
            end
            if (s_if.Pix_Tick_Out === 1'b1 && s_if.Disp_Ena_Out === 1'b1)
                de_cnt++;
        end
    endtask

    initial begin
        int k;
        repeat (3) cyc(1'b1);
        repeat (3 * S_FRAME + 40) cyc(1'b0);

        // Reset while both syncs are active, then resume from (0,0).
        k = 0;
        while (!(es.hs == 1'b0 && es.vs == 1'b0) && k < 4 * S_FRAME) begin
            cyc(1'b0);
            k++;
        end
        chk("wait_sync_low_timeout", 32'(k >= 4 * S_FRAME), 32'd0);
        cyc(1'b1);
        repeat (2 * S_FRAME) cyc(1'b0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 600)) cyc(1'b0);
            repeat ($urandom_range(1, 3)) cyc(1'b1);
        end

        repeat (7000) cyc(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
